// File: rtl/accum_alu.sv
// Two-cycle accumulator ALU: a request is accepted in READY, and the result and flags register on the next edge.
// Arithmetic or shift faults park the FSM in ERROR until err_clr; start is ignored while busy (no queuing).
module accum_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             overflow,
  output logic             error
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_ARITH = 2'd1,
    S_LOGIC = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t           state_q;
  logic [2:0]       funct_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic             ovf_q;
  logic             err_q;
  logic             done_q;

  logic [WIDTH-1:0]   alu_res_d;
  logic               alu_c_d;
  logic               alu_v_d;
  logic               alu_err_d;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [SHW-1:0]     sh_amt;
  logic [2*WIDTH-1:0] shl_w;
  logic [2*WIDTH-1:0] shr_w;

  assign sum_w  = {1'b0, opa_q} + {1'b0, opb_q};
  assign diff_w = {1'b0, opa_q} - {1'b0, opb_q};
  assign sh_amt = opb_q[SHW-1:0];
  // Shift in a double-width frame so the bits pushed out land in the spare half.
  assign shl_w  = {{WIDTH{1'b0}}, opa_q} << sh_amt;
  assign shr_w  = {opa_q, {WIDTH{1'b0}}} >> sh_amt;

  always_comb begin
    alu_res_d = '0;
    alu_c_d   = 1'b0;
    alu_v_d   = 1'b0;
    case (funct_q)
      3'd0: begin
        alu_res_d = sum_w[WIDTH-1:0];
        alu_c_d   = sum_w[WIDTH];
        alu_v_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                    (sum_w[WIDTH-1] != opa_q[WIDTH-1]);
      end
      3'd1: begin
        alu_res_d = diff_w[WIDTH-1:0];
        alu_c_d   = diff_w[WIDTH];
        alu_v_d   = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) &&
                    (diff_w[WIDTH-1] != opa_q[WIDTH-1]);
      end
      3'd2: begin
        alu_res_d = shl_w[WIDTH-1:0];
        alu_c_d   = |shl_w[2*WIDTH-1:WIDTH];
      end
      3'd3: begin
        alu_res_d = shr_w[2*WIDTH-1:WIDTH];
        alu_c_d   = |shr_w[WIDTH-1:0];
      end
      3'd4:    alu_res_d = opa_q & opb_q;
      3'd5:    alu_res_d = opa_q | opb_q;
      3'd6:    alu_res_d = opa_q ^ opb_q;
      default: alu_res_d = ~opa_q;
    endcase
  end

  // add/sub fault on signed overflow, shifts fault on lost bits, logic ops never fault
  assign alu_err_d = !funct_q[2] && (funct_q[1] ? alu_c_d : alu_v_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_READY;
      funct_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_READY: begin
          done_q <= 1'b0;
          if (start) begin
            funct_q <= funct;
            opa_q   <= use_acc ? acc_q : a;
            opb_q   <= b;
            state_q <= funct[2] ? S_LOGIC : S_ARITH;
          end
        end
        S_ARITH, S_LOGIC: begin
          result_q <= alu_res_d;
          carry_q  <= alu_c_d;
          ovf_q    <= alu_v_d;
          done_q   <= 1'b1;
          if (alu_err_d) begin
            err_q   <= 1'b1;
            state_q <= S_ERROR;
          end else begin
            acc_q   <= alu_res_d;
            err_q   <= 1'b0;
            state_q <= S_READY;
          end
        end
        S_ERROR: begin
          done_q <= 1'b0;
          if (err_clr) begin
            err_q   <= 1'b0;
            state_q <= S_READY;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_READY;
        end
      endcase
    end
  end

  assign state    = state_q;
  assign busy     = (state_q != S_READY);
  assign done     = done_q;
  assign result   = result_q;
  assign acc      = acc_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign error    = err_q;

endmodule

// File: tb/tb_accum_alu.sv
// Bench for accum_alu: directed scenarios followed by randomized operations,
// checked against a transaction-level arithmetic reference model.
module tb_accum_alu;

  localparam int W    = 8;
  localparam int MOD  = 1 << W;
  localparam int HALF = MOD / 2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   funct;
  logic         use_acc;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         err_clr;
  logic [1:0]   state;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] acc;
  logic         carry;
  logic         overflow;
  logic         error;

  int checks   = 0;
  int failures = 0;

  int m_acc, m_res, m_c, m_v, m_e, m_state;

  accum_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct), .use_acc(use_acc),
    .a(a), .b(b), .err_clr(err_clr), .state(state), .busy(busy), .done(done),
    .result(result), .acc(acc), .carry(carry), .overflow(overflow), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned/signed interpretations.
  function automatic void model(input int f, input int opa, input int opb,
                                output int res, output int c, output int v);
    int sa, sb, s, n;
    sa = (opa >= HALF) ? opa - MOD : opa;
    sb = (opb >= HALF) ? opb - MOD : opb;
    n  = opb % W;
    c  = 0;
    v  = 0;
    case (f)
      0: begin s = opa + opb; res = s % MOD; c = int'(s >= MOD);
               v = int'((sa + sb > HALF - 1) || (sa + sb < -HALF)); end
      1: begin s = opa - opb; res = (s + MOD) % MOD; c = int'(s < 0);
               v = int'((sa - sb > HALF - 1) || (sa - sb < -HALF)); end
      2: begin s = opa * (1 << n); res = s % MOD; c = int'(s >= MOD); end
      3: begin res = opa / (1 << n); c = int'((opa % (1 << n)) != 0); end
      4: res = opa & opb;
      5: res = opa | opb;
      6: res = opa ^ opb;
      default: res = MOD - 1 - opa;
    endcase
  endfunction

  task automatic check_regs(input string tag);
    check({tag, ".result"},   result,   m_res);
    check({tag, ".acc"},      acc,      m_acc);
    check({tag, ".carry"},    carry,    m_c);
    check({tag, ".overflow"}, overflow, m_v);
    check({tag, ".error"},    error,    m_e);
    check({tag, ".state"},    state,    m_state);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".state"},    state,    0);
    check({tag, ".busy"},     busy,     0);
    check({tag, ".done"},     done,     0);
    check({tag, ".result"},   result,   0);
    check({tag, ".acc"},      acc,      0);
    check({tag, ".carry"},    carry,    0);
    check({tag, ".overflow"}, overflow, 0);
    check({tag, ".error"},    error,    0);
  endtask

  // One full operation; noise=1 scrambles inputs while busy to prove they are ignored.
  task automatic do_op(input int f, input int ua, input int av, input int bv, input bit noise);
    int opa, res, c, v, e, hold;
    opa = ua ? m_acc : av;
    model(f, opa, bv, res, c, v);
    e = int'(((f == 0 || f == 1) && v != 0) || ((f == 2 || f == 3) && c != 0));

    @(negedge clk);
    start = 1'b1; funct = 3'(f); use_acc = ua[0]; a = W'(av); b = W'(bv);
    err_clr = noise ? 1'($urandom) : 1'b0;
    @(posedge clk); #1;
    check("accept.state", state, (f < 4) ? 1 : 2);
    check("accept.busy", busy, 1);
    check("accept.done", done, 0);

    @(negedge clk);
    if (noise) begin
      start = 1'($urandom); funct = 3'($urandom); use_acc = 1'($urandom);
      a = W'($urandom); b = W'($urandom); err_clr = 1'($urandom);
    end else begin
      start = 1'b0;
    end
    @(posedge clk); #1;
    m_res = res; m_c = c; m_v = v; m_e = e;
    if (e != 0) m_state = 3;
    else begin m_state = 0; m_acc = res; end
    check("done.pulse", done, 1);
    check_regs("done");

    @(negedge clk);
    start = 1'b0; err_clr = 1'b0;
    if (e != 0) begin
      hold = $urandom_range(3, 1);
      for (int k = 0; k < hold; k++) begin
        start = 1'($urandom); a = W'($urandom); funct = 3'($urandom);
        @(posedge clk); #1;
        check("err.hold.state", state, 3);
        check("err.hold.done", done, 0);
        check("err.hold.busy", busy, 1);
        @(negedge clk);
      end
      err_clr = 1'b1; start = 1'($urandom);
      @(posedge clk); #1;
      m_e = 0; m_state = 0;
      check_regs("err.clr");
      check("err.clr.done", done, 0);
      @(negedge clk);
      err_clr = 1'b0; start = 1'b0;
    end else begin
      @(posedge clk); #1;
      check("idle.done", done, 0);
      check("idle.state", state, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; funct = '0; use_acc = 1'b0;
    a = '0; b = '0; err_clr = 1'b0;
    m_acc = 0; m_res = 0; m_c = 0; m_v = 0; m_e = 0; m_state = 0;
    #1;
    check_reset("por");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // simple add, first start right after reset release
    do_op(0, 0, 100, 27, 1'b0);
    check("add.result", result, 127);
    check("add.acc", acc, 127);

    // signed overflow -> ERROR, acc retained
    do_op(0, 0, 127, 1, 1'b0);
    check("ovf.result", result, 8'h80);
    check("ovf.overflow", overflow, 1);
    check("ovf.acc", acc, 127);

    // shifts: lost bit faults, clean shift updates acc
    do_op(2, 0, 8'h81, 1, 1'b0);
    check("shl.result", result, 8'h02);
    check("shl.carry", carry, 1);
    do_op(3, 0, 8'h80, 7, 1'b0);
    check("shr.result", result, 8'h01);
    check("shr.carry", carry, 0);
    check("shr.acc", acc, 8'h01);

    // accumulator chain
    do_op(4, 0, 8'h0F, 8'hFF, 1'b0);
    check("chain.and.acc", acc, 8'h0F);
    do_op(6, 1, 0, 8'hFF, 1'b0);
    check("chain.xor.acc", acc, 8'hF0);
    do_op(1, 1, 0, 8'hF1, 1'b0);
    check("chain.sub.result", result, 8'hFF);
    check("chain.sub.borrow", carry, 1);
    check("chain.sub.overflow", overflow, 0);
    check("chain.sub.acc", acc, 8'hFF);

    // start held for 4 edges: accept, done, accept, done
    @(negedge clk);
    start = 1'b1; funct = 3'd0; use_acc = 1'b0; a = 8'd1; b = 8'd1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("hold.state", state, (k % 2 == 0) ? 1 : 0);
      check("hold.busy", busy, (k % 2 == 0) ? 1 : 0);
      check("hold.done", done, (k % 2 == 0) ? 0 : 1);
      check("hold.acc", acc, (k == 0) ? 8'hFF : 2);
    end
    @(negedge clk);
    start = 1'b0;
    m_acc = 2; m_res = 2; m_c = 0; m_v = 0; m_e = 0; m_state = 0;
    @(posedge clk); #1;
    check("hold.after.done", done, 0);
    check_regs("hold.after");

    // reset in ARITH: asynchronous clear, no done pulse
    @(negedge clk);
    start = 1'b1; funct = 3'd0; use_acc = 1'b0; a = 8'd5; b = 8'd9;
    @(posedge clk); #1;
    check("rst.pre.state", state, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset("rst.async");
    start = 1'b0;
    @(posedge clk); #1;
    check_reset("rst.held");
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = 0; m_res = 0; m_c = 0; m_v = 0; m_e = 0; m_state = 0;
    do_op(0, 0, 100, 27, 1'b0);
    check("rst.redo.result", result, 127);
    check("rst.redo.acc", acc, 127);

    // randomized operations
    for (int n = 0; n < 250; n++) begin
      do_op(int'($urandom_range(7, 0)), int'($urandom_range(1, 0)),
            int'($urandom_range(MOD - 1, 0)), int'($urandom_range(MOD - 1, 0)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
